// File: rtl/spi_bridge_pkg.sv
// Shared opcodes and FSM encoding for the SPI-to-register-bus bridge.
package spi_bridge_pkg;

  // Command word opcode, taken from the top two bits of the first word.
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  // S_CMD_RD: read command seen, first register value not yet captured.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CMD_RD = 2'd1,
    S_RD     = 2'd2,
    S_WR     = 2'd3
  } state_e;

endpackage

// File: rtl/spi_reg_bridge_if.sv
// Register bus between the bridge (master) and the register file (slave).
interface spi_reg_bridge_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 16
) ();

  logic [ADDR_W-1:0] reg_addr;
  logic [WORD_W-1:0] reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [WORD_W-1:0] reg_rdata;

  modport master (
    output reg_addr, reg_wdata, reg_we, reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_we, reg_re,
    output reg_rdata
  );

endinterface

// File: rtl/spi_reg_bridge_sync.sv
// Brings the asynchronous SPI pins into SYS_CLK and derives edge strobes.
// SPI_CLK and SSEL get three stages so the edge compare on [2:1] works on
// already-settled values; MOSI only needs two since it is sampled on a
// detected SPI_CLK edge, half an SPI period after it last changed.
module spi_sync (
  input  logic SYS_CLK,
  input  logic SYS_RST_N,
  input  logic SPI_CLK,
  input  logic SSEL,
  input  logic MOSI,
  output logic spi_rise,
  output logic spi_fall,
  output logic ssel_rise,
  output logic ssel_fall,
  output logic sel,
  output logic mosi_s
);

  logic [2:0] sclk_q;
  logic [2:0] ssel_q;
  logic [1:0] mosi_q;

  // Synchroniser chains. SSEL resets to 0 so that a master already holding
  // SSEL low across reset release produces no falling edge (no re-arm).
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      sclk_q <= '0;
      ssel_q <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SPI_CLK};
      ssel_q <= {ssel_q[1:0], SSEL};
      mosi_q <= {mosi_q[0], MOSI};
    end
  end

  assign spi_rise  =  sclk_q[1] & ~sclk_q[2];
  assign spi_fall  = ~sclk_q[1] &  sclk_q[2];
  assign ssel_rise =  ssel_q[1] & ~ssel_q[2];
  assign ssel_fall = ~ssel_q[1] &  ssel_q[2];
  assign sel       = ~ssel_q[1];
  assign mosi_s    =  mosi_q[1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave bridging an external master onto a generic register bus.
// First word of a frame is a command (opcode + address); following words are
// burst data with auto-incrementing address. WORD_W must be >= ADDR_W+2.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int                WORD_W  = 16,
  parameter int                ADDR_W  = 10,
  parameter logic [WORD_W-1:0] ID_WORD = 16'h4A53
) (
  input  logic             SYS_CLK,
  input  logic             SYS_RST_N,
  input  logic             SPI_CLK,
  input  logic             SSEL,
  input  logic             MOSI,
  output logic             MISO,
  spi_reg_bridge_if.master bus,
  output logic             frame_abort
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic spi_rise, spi_fall, ssel_rise, ssel_fall, sel, mosi_s;

  // Receive side
  logic              armed;
  logic [CNT_W-1:0]  bitcnt;
  logic [WORD_W-1:0] rx;
  logic              word_done;
  logic              abort_q;

  // Transmit side
  logic [WORD_W-1:0] tx;
  logic [WORD_W-1:0] pending, pending_nxt;

  // FSM and bus datapath
  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-1:0] raddr_q, raddr_nxt;
  logic [WORD_W-1:0] wdata_q, wdata_nxt;
  logic              we_q, we_nxt;
  logic              re_nxt;
  // [0] is the read strobe itself, [1] marks the cycle reg_rdata is valid.
  logic [1:0]        vld_pipe;

  logic [1:0]        op;
  logic [ADDR_W-1:0] cmd_addr;

  assign op       = rx[WORD_W-1 -: 2];
  assign cmd_addr = rx[ADDR_W-1:0];

  spi_sync u_sync (
    .SYS_CLK   (SYS_CLK),
    .SYS_RST_N (SYS_RST_N),
    .SPI_CLK   (SPI_CLK),
    .SSEL      (SSEL),
    .MOSI      (MOSI),
    .spi_rise  (spi_rise),
    .spi_fall  (spi_fall),
    .ssel_rise (ssel_rise),
    .ssel_fall (ssel_fall),
    .sel       (sel),
    .mosi_s    (mosi_s)
  );

  // Shift MOSI in on SPI rising edges; 'armed' blocks a frame that was cut by
  // reset until the master starts a fresh one with an SSEL falling edge.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      armed     <= 1'b0;
      bitcnt    <= '0;
      rx        <= '0;
      word_done <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      word_done <= 1'b0;
      abort_q   <= 1'b0;
      if (ssel_fall) begin
        armed  <= 1'b1;
        bitcnt <= '0;
      end else if (ssel_rise) begin
        // A partial word is simply dropped; only the abort pulse remains.
        abort_q <= (bitcnt != '0);
        armed   <= 1'b0;
        bitcnt  <= '0;
      end else if (spi_rise && armed && sel) begin
        rx        <= {rx[WORD_W-2:0], mosi_s};
        bitcnt    <= (bitcnt == LAST_BIT) ? '0 : bitcnt + CNT_W'(1);
        word_done <= (bitcnt == LAST_BIT);
      end
    end
  end

  // MISO shifter: reload the pending word at frame start and at every word
  // boundary (bitcnt already wrapped to 0), otherwise shift out MSB first.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      tx <= '0;
    end else if (ssel_fall) begin
      tx <= pending;
    end else if (spi_fall && armed) begin
      tx <= (bitcnt == '0) ? pending : {tx[WORD_W-2:0], 1'b0};
    end
  end

  // FSM state register.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next state, bus strobes and burst address. A word that completes on the
  // same cycle SSEL is released is still acted on before returning to idle.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    raddr_nxt   = raddr_q;
    wdata_nxt   = wdata_q;
    we_nxt      = 1'b0;
    re_nxt      = 1'b0;
    pending_nxt = pending;

    case (state)
      S_IDLE: begin
        if (word_done) begin
          case (op)
            OP_RD: begin
              state_nxt = S_CMD_RD;
              addr_nxt  = cmd_addr;
              raddr_nxt = cmd_addr;
              re_nxt    = 1'b1;
            end
            OP_WR: begin
              state_nxt = S_WR;
              addr_nxt  = cmd_addr;
            end
            default: ;
          endcase
        end
      end

      S_CMD_RD, S_RD: begin
        // Capture first so a coinciding word_done reads the next address.
        if (vld_pipe[1]) begin
          pending_nxt = bus.reg_rdata;
          addr_nxt    = addr + ADDR_W'(1);
          state_nxt   = S_RD;
        end
        if (word_done) begin
          raddr_nxt = addr_nxt;
          re_nxt    = 1'b1;
        end
      end

      S_WR: begin
        if (word_done) begin
          raddr_nxt = addr;
          wdata_nxt = rx;
          we_nxt    = 1'b1;
          addr_nxt  = addr + ADDR_W'(1);
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    if (ssel_rise) state_nxt = S_IDLE;

    // Every frame opens with the ID word.
    if (state_nxt == S_IDLE) pending_nxt = ID_WORD;
  end

  // Datapath registers driven by the FSM.
  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      addr     <= '0;
      raddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      vld_pipe <= '0;
      pending  <= ID_WORD;
    end else begin
      addr     <= addr_nxt;
      raddr_q  <= raddr_nxt;
      wdata_q  <= wdata_nxt;
      we_q     <= we_nxt;
      vld_pipe <= {vld_pipe[0], re_nxt};
      pending  <= pending_nxt;
    end
  end

  assign bus.reg_addr  = raddr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = vld_pipe[0];
  assign frame_abort   = abort_q;
  assign MISO          = tx[WORD_W-1];

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: table of SPI frames with expected MISO
// words and register-bus traffic, plus abort and reset-mid-frame sequences.
module tb_spi_reg_bridge;

  localparam int HALF = 8; // SYS_CLK cycles per SPI half period

  logic SYS_CLK = 1'b0;
  logic SYS_RST_N = 1'b0;
  logic SPI_CLK = 1'b0;
  logic SSEL = 1'b1;
  logic MOSI = 1'b0;
  logic MISO;
  logic frame_abort;

  spi_reg_bridge_if #(.ADDR_W(10), .WORD_W(16)) bus ();

  spi_reg_bridge #(.WORD_W(16), .ADDR_W(10), .ID_WORD(16'h4A53)) dut (
    .SYS_CLK     (SYS_CLK),
    .SYS_RST_N   (SYS_RST_N),
    .SPI_CLK     (SPI_CLK),
    .SSEL        (SSEL),
    .MOSI        (MOSI),
    .MISO        (MISO),
    .bus         (bus.master),
    .frame_abort (frame_abort)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  // Register file model: data = address + 0x1000, one cycle after reg_re.
  always @(posedge SYS_CLK) begin
    if (bus.reg_re) bus.reg_rdata <= {6'd0, bus.reg_addr} + 16'h1000;
  end
  initial bus.reg_rdata = '0;

  // Bus monitor, cumulative over the whole run.
  int          we_cnt = 0, re_cnt = 0, ab_cnt = 0, both_cnt = 0;
  logic [9:0]  we_a_log [64];
  logic [15:0] we_d_log [64];

  always @(negedge SYS_CLK) begin
    if (bus.reg_we) begin
      we_a_log[we_cnt[5:0]] <= bus.reg_addr;
      we_d_log[we_cnt[5:0]] <= bus.reg_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (bus.reg_re)              re_cnt   <= re_cnt + 1;
    if (frame_abort)             ab_cnt   <= ab_cnt + 1;
    if (bus.reg_we && bus.reg_re) both_cnt <= both_cnt + 1;
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  // Send the top nb bits of w, MSB first; MISO captured just before each rise.
  task automatic xfer_bits(input logic [15:0] w, input int nb, output logic [15:0] r);
    r = '0;
    for (int b = 0; b < nb; b++) begin
      MOSI = w[15-b];
      wait_clk(HALF);
      r = {r[14:0], MISO};
      SPI_CLK = 1'b1;
      wait_clk(HALF);
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic run_frame(input int n, input logic [0:3][15:0] mo, output logic [0:3][15:0] mi);
    logic [15:0] r;
    mi = '0;
    SSEL = 1'b0;
    wait_clk(HALF);
    for (int w = 0; w < n; w++) begin
      xfer_bits(mo[w], 16, r);
      mi[w] = r;
    end
    wait_clk(HALF);
    SSEL = 1'b1;
    wait_clk(4 * HALF);
  endtask

  typedef struct {
    int               n;
    logic [0:3][15:0] mosi;
    logic [0:3][15:0] miso;
    int               nwe;
    int               nre;
    logic [0:2][9:0]  we_a;
    logic [0:2][15:0] we_d;
  } vec_t;

  vec_t vt [7];

  task automatic set_vec(input int i, input int n, input logic [0:3][15:0] mo,
                         input logic [0:3][15:0] mi, input int nwe, input int nre,
                         input logic [0:2][9:0] a, input logic [0:2][15:0] d);
    vt[i].n = n;  vt[i].mosi = mo; vt[i].miso = mi;
    vt[i].nwe = nwe; vt[i].nre = nre; vt[i].we_a = a; vt[i].we_d = d;
  endtask

  initial begin
    logic [0:3][15:0] mi;
    logic [15:0] r;
    int we0, re0, ab0;

    set_vec(0, 1, {16'h0000, 16'h0, 16'h0, 16'h0}, {16'h4A53, 16'h0, 16'h0, 16'h0},
            0, 0, {10'h0, 10'h0, 10'h0}, {16'h0, 16'h0, 16'h0});
    set_vec(1, 2, {16'h4019, 16'h05DC, 16'h0, 16'h0}, {16'h4A53, 16'h4A53, 16'h0, 16'h0},
            1, 0, {10'd25, 10'h0, 10'h0}, {16'h05DC, 16'h0, 16'h0});
    set_vec(2, 4, {16'h4021, 16'h0100, 16'h0200, 16'h0300}, {16'h4A53, 16'h4A53, 16'h4A53, 16'h4A53},
            3, 0, {10'd33, 10'd34, 10'd35}, {16'h0100, 16'h0200, 16'h0300});
    set_vec(3, 4, {16'h8002, 16'h0, 16'h0, 16'h0}, {16'h4A53, 16'h1002, 16'h1003, 16'h1004},
            0, 4, {10'h0, 10'h0, 10'h0}, {16'h0, 16'h0, 16'h0});
    set_vec(4, 3, {16'h43FF, 16'hAAAA, 16'h5555, 16'h0}, {16'h4A53, 16'h4A53, 16'h4A53, 16'h0},
            2, 0, {10'h3FF, 10'h000, 10'h0}, {16'hAAAA, 16'h5555, 16'h0});
    set_vec(5, 3, {16'h83FE, 16'h0, 16'h0, 16'h0}, {16'h4A53, 16'h13FE, 16'h13FF, 16'h0},
            0, 3, {10'h0, 10'h0, 10'h0}, {16'h0, 16'h0, 16'h0});
    set_vec(6, 2, {16'hC123, 16'h4005, 16'h0, 16'h0}, {16'h4A53, 16'h4A53, 16'h0, 16'h0},
            0, 0, {10'h0, 10'h0, 10'h0}, {16'h0, 16'h0, 16'h0});

    // Reset state
    wait_clk(3);
    check("rst MISO", 32'(MISO), 32'h0);
    check("rst reg_we", 32'(bus.reg_we), 32'h0);
    check("rst reg_re", 32'(bus.reg_re), 32'h0);
    check("rst reg_addr", 32'(bus.reg_addr), 32'h0);
    check("rst reg_wdata", 32'(bus.reg_wdata), 32'h0);
    check("rst frame_abort", 32'(frame_abort), 32'h0);
    SYS_RST_N = 1'b1;
    wait_clk(4 * HALF);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      we0 = we_cnt; re0 = re_cnt; ab0 = ab_cnt;
      run_frame(vt[i].n, vt[i].mosi, mi);
      for (int w = 0; w < vt[i].n; w++)
        check($sformatf("vec%0d miso word%0d", i, w), 32'(mi[w]), 32'(vt[i].miso[w]));
      check($sformatf("vec%0d we count", i), 32'(we_cnt - we0), 32'(vt[i].nwe));
      check($sformatf("vec%0d re count", i), 32'(re_cnt - re0), 32'(vt[i].nre));
      check($sformatf("vec%0d abort count", i), 32'(ab_cnt - ab0), 32'h0);
      for (int k = 0; k < vt[i].nwe; k++) begin
        check($sformatf("vec%0d we%0d addr", i, k), 32'(we_a_log[(we0 + k) % 64]), 32'(vt[i].we_a[k]));
        check($sformatf("vec%0d we%0d data", i, k), 32'(we_d_log[(we0 + k) % 64]), 32'(vt[i].we_d[k]));
      end
    end

    // Abort: SSEL released after 7 bits of a write data word
    we0 = we_cnt; ab0 = ab_cnt;
    SSEL = 1'b0;
    wait_clk(HALF);
    xfer_bits(16'h4019, 16, r);
    xfer_bits(16'h05DC, 7, r);
    wait_clk(HALF);
    SSEL = 1'b1;
    wait_clk(4 * HALF);
    check("abort pulse count", 32'(ab_cnt - ab0), 32'h1);
    check("abort no we", 32'(we_cnt - we0), 32'h0);
    run_frame(1, {16'h0000, 16'h0, 16'h0, 16'h0}, mi);
    check("after abort id word", 32'(mi[0]), 32'h4A53);

    // Reset mid-frame: rest of that frame must be ignored
    we0 = we_cnt; re0 = re_cnt; ab0 = ab_cnt;
    SSEL = 1'b0;
    wait_clk(HALF);
    xfer_bits(16'h4019, 16, r);
    xfer_bits(16'h05DC, 5, r);
    SYS_RST_N = 1'b0;
    wait_clk(3);
    check("mid rst MISO", 32'(MISO), 32'h0);
    SYS_RST_N = 1'b1;
    wait_clk(2);
    xfer_bits(16'h05DC << 5, 11, r);
    xfer_bits(16'h1234, 16, r);
    check("post rst miso word", 32'(r), 32'h0);
    wait_clk(HALF);
    SSEL = 1'b1;
    wait_clk(4 * HALF);
    check("post rst no we", 32'(we_cnt - we0), 32'h0);
    check("post rst no re", 32'(re_cnt - re0), 32'h0);
    check("post rst no abort", 32'(ab_cnt - ab0), 32'h0);
    run_frame(2, {16'h4005, 16'hBEEF, 16'h0, 16'h0}, mi);
    check("post rst id word", 32'(mi[0]), 32'h4A53);
    check("post rst write count", 32'(we_cnt - we0), 32'h1);
    check("post rst write addr", 32'(we_a_log[we0 % 64]), 32'h5);
    check("post rst write data", 32'(we_d_log[we0 % 64]), 32'hBEEF);

    check("re/we overlap cycles", 32'(both_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
